// File: rtl/cache_writeback_buffer.sv
// Write-back (victim) buffer between the L1 cache memory port and physical memory.
// Evicted dirty lines are absorbed into a small tag-matched FIFO and drained to
// memory whenever the cache is idle; line reads pass through to memory.
// Build option: define WB_FWD_EN to return buffered data on a read hit instead of
// draining the matching entry first.
module cache_writeback_buffer #(
    parameter int DEPTH  = 2,
    parameter int LINE_W = 128,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] mem_address,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [LINE_W-1:0] mem_wdata,
    output logic [LINE_W-1:0] mem_rdata,
    output logic              mem_resp,
    output logic [ADDR_W-1:0] pmem_address,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic              wb_empty,
    output logic [2:0]        wb_count
);
    localparam int TAG_W = ADDR_W - 4;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] FULL_CNT = 3'(DEPTH);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, RESP} state_t;

    state_t            state_q, state_d;
    logic [DEPTH-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [LINE_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  head_q, tail_q;
    logic [2:0]        count_q, count_d;
    logic              empty_q;

    logic [TAG_W-1:0]  req_tag;
    logic              hit;
    logic [PTR_W-1:0]  hit_idx;
    logic              full;
    logic              do_push, do_coal, do_pop, go_read, go_drain, fwd_load, rd_latch;
    logic              addr_offset_unused;

    // Wrap a FIFO pointer modulo DEPTH.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) return '0;
        return p + PTR_W'(1);
    endfunction

    assign req_tag            = mem_address[ADDR_W-1:4];
    assign addr_offset_unused = ^mem_address[3:0];
    assign full               = (count_q == FULL_CNT);
    assign wb_count           = count_q;
    assign wb_empty           = empty_q;

    // Associative tag match across all valid entries (at most one can match).
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (tag_q[i] == req_tag)) begin
                hit     = 1'b1;
                hit_idx = PTR_W'(i);
            end
        end
    end

    // Next-state and per-cycle action decode; IDLE arms are in priority order.
    always_comb begin
        state_d  = state_q;
        do_push  = 1'b0;
        do_coal  = 1'b0;
        do_pop   = 1'b0;
        go_read  = 1'b0;
        go_drain = 1'b0;
        fwd_load = 1'b0;
        rd_latch = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_write) begin
                    if (hit) begin
                        do_coal = 1'b1;
                        state_d = RESP;
                    end else if (!full) begin
                        do_push = 1'b1;
                        state_d = RESP;
                    end else begin
                        go_drain = 1'b1;
                        state_d  = DRAIN;
                    end
                end else if (mem_read) begin
                    if (hit) begin
`ifdef WB_FWD_EN
                        fwd_load = 1'b1;
                        state_d  = RESP;
`else
                        // Flush oldest-first until the line is no longer buffered.
                        go_drain = 1'b1;
                        state_d  = DRAIN;
`endif
                    end else begin
                        go_read = 1'b1;
                        state_d = READ;
                    end
                end else if (count_q != 3'd0) begin
                    go_drain = 1'b1;
                    state_d  = DRAIN;
                end
            end
            READ: begin
                if (pmem_resp) begin
                    rd_latch = 1'b1;
                    state_d  = RESP;
                end
            end
            DRAIN: begin
                if (pmem_resp) begin
                    do_pop  = 1'b1;
                    state_d = IDLE;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Occupancy follows pushes and pops on the same edge.
    always_comb begin
        count_d = count_q;
        if (do_push) count_d = count_q + 3'd1;
        if (do_pop)  count_d = count_q - 3'd1;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Control state and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q      <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= 3'd0;
            empty_q      <= 1'b1;
            mem_resp     <= 1'b0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            mem_rdata    <= '0;
        end else begin
            mem_resp   <= (state_d == RESP);
            pmem_read  <= (state_d == READ);
            pmem_write <= (state_d == DRAIN);
            if (do_push) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= ptr_inc(tail_q);
            end
            if (do_pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= ptr_inc(head_q);
            end
            count_q <= count_d;
            empty_q <= (count_d == 3'd0);
            if (go_read)       pmem_address <= {req_tag, 4'h0};
            else if (go_drain) pmem_address <= {tag_q[head_q], 4'h0};
            if (rd_latch)      mem_rdata <= pmem_rdata;
            else if (fwd_load) mem_rdata <= data_q[hit_idx];
        end
    end

    // Line storage and drain data; contents are qualified by valid_q, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            tag_q[tail_q]  <= req_tag;
            data_q[tail_q] <= mem_wdata;
        end
        if (do_coal)  data_q[hit_idx] <= mem_wdata;
        if (go_drain) pmem_wdata      <= data_q[head_q];
    end

endmodule
